xorshift_prng: RTL

Parametrised multi-cycle xorshift pseudo-random generator for the PSEUDORAND subsystem. It replaces the fixed-width, fixed-shift buffer approach with one configurable block that performs the three shift-XOR steps sequentially, one step per clock. It holds the generator state internally, supports run-time seeding and delivers each new word with a request/valid handshake. It sits between the CPU datapath (request, seed) and any consumer of random words.

---
 rtl/prng_pkg.sv | 45 ++++
 rtl/xorshift_step.sv | 30 +++
 rtl/xorshift_prng.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/prng_pkg.sv
// ---------------------------------------------------------------------------
// prng_pkg
// Shared definitions for the xorshift pseudo-random generator:
//   - generator FSM state encoding
//   - shift direction selector for the xorshift_step sub-module
//   - default shift triple and default (non-zero) seed
//   - a table of known full-period shift triples for 16-bit state
//   - helper used by the elaboration-time parameter checks
// No ports (package).
// ---------------------------------------------------------------------------
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_A = 2'd1,
        STEP_B = 2'd2,
        STEP_C = 2'd3
    } prng_state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } shift_dir_e;

    localparam int          PRNG_DEFAULT_WIDTH   = 16;
    localparam int          PRNG_DEFAULT_SHIFT_A = 7;
    localparam int          PRNG_DEFAULT_SHIFT_B = 9;
    localparam int          PRNG_DEFAULT_SHIFT_C = 8;
    localparam logic [31:0] PRNG_DEFAULT_SEED    = 32'h0000_ACE1;

    // Full-period (2^16 - 1) triples for the left/right/left form at 16 bits.
    // A triple (a,b,c) and its mirror (c,b,a) share the same period.
    localparam int PRNG_NUM_TRIPLES16 = 2;
    localparam int PRNG_TRIPLES16 [PRNG_NUM_TRIPLES16][3] = '{
        '{7, 9, 8},
        '{8, 9, 7}
    };

    // A shift of 0 or >= WIDTH would make its step either the zero map or
    // the identity, which breaks the generator.
    function automatic bit shiftLegal(input int shift, input int width);
        return (shift >= 1) && (shift <= width - 1);
    endfunction

endpackage

// File: rtl/xorshift_step.sv
// ---------------------------------------------------------------------------
// xorshift_step
// One combinational shift-XOR step: data_o = data_i ^ (data_i <<|>> SHIFT).
// The shift is logical (zero fill) and truncated to WIDTH bits.
// Parameters:
//   WIDTH  data width in bits
//   SHIFT  shift distance
//   DIR    DIR_LEFT or DIR_RIGHT
// Ports:
//   data_i  in   WIDTH  current state word
//   data_o  out  WIDTH  state word after this step
// ---------------------------------------------------------------------------
module xorshift_step
    import prng_pkg::*;
#(
    parameter int         WIDTH = 16,
    parameter int         SHIFT = 1,
    parameter shift_dir_e DIR   = DIR_LEFT
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DIR == DIR_LEFT) begin : g_left
        assign data_o = data_i ^ (data_i << SHIFT);
    end else begin : g_right
        assign data_o = data_i ^ (data_i >> SHIFT);
    end

endmodule

// File: rtl/xorshift_prng.sv
// ---------------------------------------------------------------------------
// xorshift_prng
// Multi-cycle xorshift generator. A request in IDLE runs three shift-XOR
// steps (left A, right B, left C), one per clock, then presents the new word
// on rand_out with a one-cycle valid pulse. The state can be reseeded in
// IDLE; a zero seed is replaced by DEFAULT_SEED so the state never sticks
// at zero.
// Parameters:
//   WIDTH         state/output width (4..32)
//   SHIFT_A/B/C   step shift distances, each 1..WIDTH-1
//   DEFAULT_SEED  reset/zero-seed substitute, truncated to WIDTH, non-zero
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   seed_load  in   1      load seed (IDLE only, wins over req)
//   seed       in   WIDTH  seed value
//   req        in   1      request one new word (IDLE only)
//   busy       out  1      generation in progress
//   valid      out  1      one-cycle pulse, rand_out just updated
//   rand_out   out  WIDTH  last generated word
// ---------------------------------------------------------------------------
module xorshift_prng
    import prng_pkg::*;
#(
    parameter int          WIDTH        = PRNG_DEFAULT_WIDTH,
    parameter int          SHIFT_A      = PRNG_DEFAULT_SHIFT_A,
    parameter int          SHIFT_B      = PRNG_DEFAULT_SHIFT_B,
    parameter int          SHIFT_C      = PRNG_DEFAULT_SHIFT_C,
    parameter logic [31:0] DEFAULT_SEED = PRNG_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] rand_out
);

    localparam logic [WIDTH-1:0] SEED_INIT = DEFAULT_SEED[WIDTH-1:0];

    // Reject parameter sets that cannot produce a working generator.
    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "xorshift_prng: WIDTH must lie in 4..32");
    end
    if (!shiftLegal(SHIFT_A, WIDTH)) begin : g_bad_shift_a
        $fatal(1, "xorshift_prng: SHIFT_A must lie in 1..WIDTH-1");
    end
    if (!shiftLegal(SHIFT_B, WIDTH)) begin : g_bad_shift_b
        $fatal(1, "xorshift_prng: SHIFT_B must lie in 1..WIDTH-1");
    end
    if (!shiftLegal(SHIFT_C, WIDTH)) begin : g_bad_shift_c
        $fatal(1, "xorshift_prng: SHIFT_C must lie in 1..WIDTH-1");
    end
    if (SEED_INIT == '0) begin : g_bad_seed
        $fatal(1, "xorshift_prng: DEFAULT_SEED truncated to WIDTH is zero");
    end

    prng_state_e      state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] rand_q, rand_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] stepA, stepB, stepC;

    // All three steps look at the current state; the FSM picks the one that
    // belongs to the current phase.
    xorshift_step #(.WIDTH(WIDTH), .SHIFT(SHIFT_A), .DIR(DIR_LEFT)) uStepA (
        .data_i (x_q),
        .data_o (stepA)
    );

    xorshift_step #(.WIDTH(WIDTH), .SHIFT(SHIFT_B), .DIR(DIR_RIGHT)) uStepB (
        .data_i (x_q),
        .data_o (stepB)
    );

    xorshift_step #(.WIDTH(WIDTH), .SHIFT(SHIFT_C), .DIR(DIR_LEFT)) uStepC (
        .data_i (x_q),
        .data_o (stepC)
    );

    // State, generator word, output word and valid pulse registers. Reset
    // also aborts any generation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= SEED_INIT;
            rand_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic. Inputs are only looked at in IDLE, so anything
    // arriving while busy is simply dropped. A seed load beats a request
    // in the same cycle.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        rand_d  = rand_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    x_d = (seed == '0) ? SEED_INIT : seed;
                end else if (req) begin
                    state_d = STEP_A;
                end
            end
            STEP_A: begin
                x_d     = stepA;
                state_d = STEP_B;
            end
            STEP_B: begin
                x_d     = stepB;
                state_d = STEP_C;
            end
            STEP_C: begin
                x_d     = stepC;
                rand_d  = stepC;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign valid    = valid_q;
    assign rand_out = rand_q;

endmodule
